// File: rtl/c_ddr_rd_pkg.sv
// Package: c_ddr_rd_pkg
// Purpose: Shared types and constants for the DDR read master (c_ddr_rd_master)
//          and its return-buffer FIFO (c_ddr_rd_fifo).
// Contents:
//   AW, DW, LW, BST_W            address, data, descriptor-length and burst-length widths
//   DEF_MAX_BST, DEF_FIFO_DEPTH  default values for the top-level parameters
//   state_t                      FSM state encoding {IDLE, ISSUE, DRAIN}
//   fifo_entry_t                 one buffered beat: {last, data}

package c_ddr_rd_pkg;

    localparam int AW             = 26;
    localparam int DW             = 512;
    localparam int LW             = 16;
    localparam int BST_W          = 7;
    localparam int DEF_MAX_BST    = 64;
    localparam int DEF_FIFO_DEPTH = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/c_ddr_rd_fifo.sv
// Module: c_ddr_rd_fifo
// Purpose: Synchronous first-word-fall-through FIFO of fifo_entry_t. The head
//          entry is visible on o_rdata whenever o_empty is low.
//          Push and pop may occur in the same cycle at any fill level.
//          The writer never pushes into a full FIFO unless it also pops in that cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers only)
//   i_push      write i_wdata at the tail
//   i_wdata     entry to write
//   i_pop       remove the head entry; ignored when empty
//   o_rdata     head entry
//   o_empty     no entries held
//   o_count     number of entries held, 0..DEPTH

module c_ddr_rd_fifo
    import c_ddr_rd_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  fifo_entry_t              i_wdata,
    input  logic                     i_pop,
    output fifo_entry_t              o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    fifo_entry_t r_mem [DEPTH];
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    logic        w_pop;

    assign w_pop = i_pop && !o_empty;

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Pointers carry one extra wrap bit, so full and empty are distinguishable.
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/c_ddr_rd_master.sv
// Module: c_ddr_rd_master
// Purpose: Read-side master for the c_ddr_intf DDR port. It accepts one read
//          descriptor at a time and splits it into bursts of at most MAX_BST beats.
//          A burst is issued only when the return FIFO has room for every outstanding beat.
//          Returned beats stream to the consumer with valid/ready and a last flag.
// Configuration: define DDR_RD_PERF_EN to build the saturating stall counter
//          (perf_stall). Without it, perf_stall is tied to 0.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   desc_vld/desc_rdy                descriptor handshake
//   desc_addr, desc_len              start word address, length in beats (0 = no-op)
//   rd_req/ddr_rdy                   DDR request handshake
//   cmd_addr, bst_len, avl_be        request fields; avl_be is constant all-ones
//   ddr_vld, data_out                returned read beats (no backpressure)
//   dout_vld/dout_rdy, dout, dout_last  output stream
//   busy                             FSM active or beats still buffered
//   err_unexp                        sticky: beat returned with nothing outstanding
//   perf_stall                       stall cycle counter (DDR_RD_PERF_EN)

module c_ddr_rd_master
    import c_ddr_rd_pkg::*;
#(
    parameter int MAX_BST    = DEF_MAX_BST,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              desc_vld,
    output logic              desc_rdy,
    input  logic [AW-1:0]     desc_addr,
    input  logic [LW-1:0]     desc_len,
    output logic              rd_req,
    output logic [AW-1:0]     cmd_addr,
    output logic [BST_W-1:0]  bst_len,
    output logic [DW/8-1:0]   avl_be,
    input  logic              ddr_rdy,
    input  logic              ddr_vld,
    input  logic [DW-1:0]     data_out,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic [DW-1:0]     dout,
    output logic              dout_last,
    output logic              busy,
    output logic              err_unexp,
    output logic [31:0]       perf_stall
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;  // holds 0..FIFO_DEPTH
    localparam int KW = CW + 1;                  // headroom for credit arithmetic

    state_t             r_state;
    logic               r_desc_rdy;
    logic               r_rd_req;
    logic [AW-1:0]      r_cmd_addr;
    logic [BST_W-1:0]   r_bst_len;
    logic [AW-1:0]      r_nxt_addr;
    logic [LW-1:0]      r_remaining;
    logic [LW-1:0]      r_rx_left;
    logic [CW-1:0]      r_outstanding;
    logic               r_err_unexp;

    logic [CW-1:0]      w_fifo_count;
    logic               w_fifo_empty;
    fifo_entry_t        w_fifo_wdata;
    fifo_entry_t        w_fifo_rdata;
    logic               w_req_accept;
    logic               w_rx_accept;
    logic [BST_W-1:0]   w_blen;
    logic [BST_W-1:0]   w_blen_next;
    logic [LW-1:0]      w_remaining_next;
    logic [AW-1:0]      w_addr_next;
    logic [KW-1:0]      w_credit;
    logic [KW-1:0]      w_credit_next;

    assign w_req_accept = r_rd_req && ddr_rdy;
    assign w_rx_accept  = ddr_vld && (r_outstanding != '0);

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_blen           = (r_remaining > LW'(MAX_BST)) ? BST_W'(MAX_BST) : BST_W'(r_remaining);
        w_remaining_next = r_remaining - LW'(r_bst_len);
        w_blen_next      = (w_remaining_next > LW'(MAX_BST)) ? BST_W'(MAX_BST)
                                                             : BST_W'(w_remaining_next);
        w_addr_next      = r_nxt_addr + AW'(r_bst_len);
        // Free FIFO slots not yet promised to an in-flight beat.
        w_credit         = KW'(FIFO_DEPTH) - KW'(w_fifo_count) - KW'(r_outstanding);
        // Lower bound on credit once the accepted burst is counted. Same-cycle
        // returns and pops can only raise it, so the bound is safe for chaining.
        w_credit_next    = w_credit - KW'(r_bst_len);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_desc_rdy  <= 1'b1;
            r_rd_req    <= 1'b0;
            r_cmd_addr  <= '0;
            r_bst_len   <= '0;
            r_nxt_addr  <= '0;
            r_remaining <= '0;
            r_rx_left   <= '0;
        end else begin
            if (w_rx_accept) r_rx_left <= r_rx_left - 1'b1;

            case (r_state)
                IDLE: begin
                    // Zero-length descriptors are accepted and dropped.
                    if (desc_vld && desc_len != '0) begin
                        r_nxt_addr  <= desc_addr;
                        r_remaining <= desc_len;
                        r_rx_left   <= desc_len;
                        r_desc_rdy  <= 1'b0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!r_rd_req) begin
                        if (w_credit >= KW'(w_blen)) begin
                            r_rd_req   <= 1'b1;
                            r_cmd_addr <= r_nxt_addr;
                            r_bst_len  <= w_blen;
                        end
                    end else if (ddr_rdy) begin
                        r_nxt_addr  <= w_addr_next;
                        r_remaining <= w_remaining_next;
                        if (w_remaining_next == '0) begin
                            r_rd_req <= 1'b0;
                            r_state  <= DRAIN;
                        end else if (w_credit_next >= KW'(w_blen_next)) begin
                            // Back-to-back: keep rd_req high and present the next burst.
                            r_cmd_addr <= w_addr_next;
                            r_bst_len  <= w_blen_next;
                        end else begin
                            r_rd_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_desc_rdy <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_err_unexp   <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding
                           + (w_req_accept ? CW'(r_bst_len) : CW'(0))
                           - CW'(w_rx_accept);
            if (ddr_vld && r_outstanding == '0) r_err_unexp <= 1'b1;
        end
    end

    assign w_fifo_wdata = '{last: (r_rx_left == LW'(1)), data: data_out};

    c_ddr_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_accept),
        .i_wdata (w_fifo_wdata),
        .i_pop   (dout_rdy),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef DDR_RD_PERF_EN
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_rd_req && !ddr_rdy)
                  || (r_state == ISSUE && !r_rd_req && w_credit < KW'(w_blen));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
        end else if (w_stall && r_perf_stall != '1) begin
            r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_stall = r_perf_stall;
`else
    assign perf_stall = '0;
`endif

    assign desc_rdy  = r_desc_rdy;
    assign rd_req    = r_rd_req;
    assign cmd_addr  = r_cmd_addr;
    assign bst_len   = r_bst_len;
    assign avl_be    = '1;
    assign dout_vld  = !w_fifo_empty;
    assign dout      = w_fifo_rdata.data;
    assign dout_last = !w_fifo_empty && w_fifo_rdata.last;
    assign busy      = (r_state != IDLE) || !w_fifo_empty;
    assign err_unexp = r_err_unexp;

endmodule
